read_unit: RTL and testbench
============================

READ_UNIT -- requirements
Module: read_unit

Interface
REQ-001 The module SHALL have parameter T_RP, default 4, meaning RE# low-phase length in clk cycles; legal range is 1 or more.
REQ-002 The module SHALL have parameter T_REH, default 2, meaning RE# high-hold length in clk cycles; legal range is 1 or more.
REQ-003 Port clk, input, width 1: the single clock; all logic is on its rising edge.
REQ-004 Port reset, input, width 1: synchronous, active-high reset.
REQ-005 Port activate, input, width 1: start request, sampled only in IDLE.
REQ-006 Port word_count, input, width 16: number of words to read, latched at start.
REQ-007 Port data_in, input, width 16: NAND IO bus.
REQ-008 Port read_enable, output, width 1: RE#, active low.
REQ-009 Port busy, output, width 1: transfer in progress.
REQ-010 Port data_out, output, width 16: last sampled word.
REQ-011 Port data_valid, output, width 1: one-cycle strobe qualifying data_out.
REQ-012 Port last, output, width 1: asserted together with data_valid on the final word.

Function
REQ-013 All outputs SHALL be registered.
REQ-014 States SHALL be exactly IDLE, RE_LOW and RE_HIGH.
REQ-015 IDLE SHALL drive read_enable=1, busy=0, data_valid=0, last=0, and hold data_out.
REQ-016 In IDLE, activate=1 with word_count≠0 at edge k SHALL:
- latch word_count into a 16-bit remaining counter;
- enter RE_LOW;
- make read_enable=0 and busy=1 visible after edge k.
REQ-017 In IDLE, activate=1 with word_count=0 SHALL be ignored: no state change and no busy assertion.
REQ-018 activate SHALL be ignored in RE_LOW and RE_HIGH.
REQ-019 RE_LOW SHALL last exactly T_RP cycles, with read_enable=0 throughout.
REQ-020 On the edge that ends RE_LOW:
- data_out <= data_in;
- data_valid=1 for exactly one cycle;
- last=1 in that same cycle if remaining==1, else last=0;
- remaining decrements by 1;
- read_enable returns to 1;
- the state becomes RE_HIGH.
REQ-021 RE_HIGH SHALL last exactly T_REH cycles with read_enable=1.
REQ-022 At the end of RE_HIGH:
- if remaining≠0, the state SHALL become RE_LOW;
- otherwise the state SHALL become IDLE, and busy SHALL deassert on that edge.
REQ-023 Timing:
- first data_valid SHALL be visible T_RP cycles after the activate edge;
- successive data_valid strobes SHALL be spaced T_RP+T_REH cycles apart;
- busy SHALL stay high for word_count*(T_RP+T_REH) cycles.
REQ-024 Phase timing SHALL use a down-counter wide enough for max(T_RP,T_REH).
- It SHALL NOT wrap or underflow.
- It SHALL reload at every phase entry.
REQ-025 word_count=16'hFFFF SHALL produce 65535 words.
- The remaining counter SHALL never wrap.
- No extra RE# pulse SHALL occur.
REQ-026 A new activate SHALL be accepted no earlier than the cycle after busy deasserts, i.e. on an edge where the state is IDLE.
REQ-027 Changes on data_in outside the sampling edge SHALL NOT affect data_out.

Reset
REQ-028 While reset=1 at an edge, the block SHALL set:
- state=IDLE;
- read_enable=1;
- busy=0, data_valid=0, last=0;
- data_out=16'h0000;
- remaining and phase counters to 0.
REQ-029 Reset SHALL take priority over activate on the same edge.
REQ-030 Reset mid-transfer SHALL abort immediately, with no further data_valid and no further RE# low pulse.

Verification (T_RP=4, T_REH=2)
REQ-031 Reset, then idle 10 cycles -> read_enable=1, busy=0, data_valid=0, data_out=16'h0000 throughout.
REQ-032 Single word: activate with word_count=1 and data_in=16'hA5C3 ->
- read_enable low 4 cycles;
- one data_valid with data_out=16'hA5C3 and last=1;
- busy high exactly 6 cycles.
REQ-033 Burst: word_count=3, data_in changes every cycle ->
- three RE# low pulses of 4 cycles;
- data_valid 6 cycles apart, each data_out equal to data_in at the sampling edge;
- last only on the third strobe;
- busy high 18 cycles.
REQ-034 Busy guard: activate pulses during a word_count=2 burst -> exactly 2 strobes; the block returns to IDLE after 12 cycles.
REQ-035 Mid-burst reset: reset asserted in the second RE_LOW of a word_count=4 burst ->
- next cycle read_enable=1, busy=0, data_out=0;
- no further strobes.
REQ-036 Zero count and reset priority:
- activate with word_count=0 -> busy stays 0 and read_enable stays 1;
- activate and reset on the same edge -> the block stays IDLE.

Source files
------------

// File: rtl/read_unit.sv
// read_unit: NAND RE#-strobed word reader with programmable low/high phase lengths
module read_unit #(
  parameter int T_RP  = 4,
  parameter int T_REH = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        activate,
  input  logic [15:0] word_count,
  input  logic [15:0] data_in,
  output logic        read_enable,
  output logic        busy,
  output logic [15:0] data_out,
  output logic        data_valid,
  output logic        last
);
  localparam int MAXP = (T_RP > T_REH) ? T_RP : T_REH;
  localparam int CW   = $clog2(MAXP + 1);
  typedef enum logic [1:0] {IDLE, RE_LOW, RE_HIGH} state_t;
  state_t state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [15:0] rem, rem_n, data_out_n;
  logic read_enable_n, busy_n, data_valid_n, last_n, done;
  assign done = cnt == '0;
  always_comb begin
    state_n       = state;
    cnt_n         = done ? '0 : cnt - 1'b1;
    rem_n         = rem;
    read_enable_n = read_enable;
    busy_n        = busy;
    data_out_n    = data_out;
    data_valid_n  = 1'b0;
    last_n        = 1'b0;
    case (state)
      IDLE: if (activate && word_count != 16'd0) begin
        state_n       = RE_LOW;
        cnt_n         = CW'(T_RP - 1);
        rem_n         = word_count;
        read_enable_n = 1'b0;
        busy_n        = 1'b1;
      end
      RE_LOW: if (done) begin
        state_n       = RE_HIGH;
        cnt_n         = CW'(T_REH - 1);
        data_out_n    = data_in;
        data_valid_n  = 1'b1;
        last_n        = rem == 16'd1;
        rem_n         = rem - 16'd1;
        read_enable_n = 1'b1;
      end
      RE_HIGH: if (done) begin
        state_n       = (rem != 16'd0) ? RE_LOW : IDLE;
        cnt_n         = (rem != 16'd0) ? CW'(T_RP - 1) : '0;
        read_enable_n = rem == 16'd0;
        busy_n        = rem != 16'd0;
      end
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      cnt         <= '0;
      rem         <= '0;
      read_enable <= 1'b1;
      busy        <= 1'b0;
      data_out    <= '0;
      data_valid  <= 1'b0;
      last        <= 1'b0;
    end else begin
      state       <= state_n;
      cnt         <= cnt_n;
      rem         <= rem_n;
      read_enable <= read_enable_n;
      busy        <= busy_n;
      data_out    <= data_out_n;
      data_valid  <= data_valid_n;
      last        <= last_n;
    end
  end
endmodule

// File: tb/tb_read_unit.sv
// tb_read_unit: directed table and burst sequences for read_unit (T_RP=4, T_REH=2)
module tb_read_unit;
  logic clk = 1'b0;
  logic reset, activate, read_enable, busy, data_valid, last;
  logic [15:0] word_count, data_in, data_out;
  int n_chk = 0;
  int n_fail = 0;
  typedef struct {
    logic rst, act;
    logic [15:0] wc, din;
    logic re, bsy, dv, lst;
    logic [15:0] dout;
  } vec_t;
  vec_t q[$];
  read_unit #(.T_RP(4), .T_REH(2)) dut (
    .clk(clk), .reset(reset), .activate(activate), .word_count(word_count),
    .data_in(data_in), .read_enable(read_enable), .busy(busy),
    .data_out(data_out), .data_valid(data_valid), .last(last)
  );
  always #5 clk = ~clk;
  task automatic drive(input logic r, input logic a, input logic [15:0] w, input logic [15:0] d);
    reset = r;
    activate = a;
    word_count = w;
    data_in = d;
    @(posedge clk);
    #1;
  endtask
  task automatic check(input string nm, input logic [19:0] exp);
    logic [19:0] got;
    got = {read_enable, busy, data_valid, last, data_out};
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got re/busy/dv/last/dout=%b/%b/%b/%b/%h expected %b/%b/%b/%b/%h",
               nm, got[19], got[18], got[17], got[16], got[15:0],
               exp[19], exp[18], exp[17], exp[16], exp[15:0]);
    end
  endtask
  task automatic add(input logic r, input logic a, input logic [15:0] w, input logic [15:0] d,
                     input logic re, input logic b, input logic dv, input logic l, input logic [15:0] o);
    vec_t v;
    v.rst = r; v.act = a; v.wc = w; v.din = d;
    v.re = re; v.bsy = b; v.dv = dv; v.lst = l; v.dout = o;
    q.push_back(v);
  endtask
  task automatic count_check(input string nm, input int got, input int exp);
    n_chk++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, got, exp);
    end
  endtask
  task automatic burst(input string nm, input int wc, input bit guard, input int rst_at,
                       input int ncyc, input int exp_strobes, input int exp_busy);
    int strobes, busy_cyc, ph;
    logic [15:0] dout_m, din;
    logic act_m, dv_m;
    strobes = 0;
    busy_cyc = 0;
    drive(1'b1, 1'b0, 16'h0, 16'h0);
    check($sformatf("%s reset", nm), {4'b1000, 16'h0000});
    dout_m = 16'h0;
    for (int c = 0; c < ncyc; c++) begin
      din = 16'h3C00 + 16'(c * 257);
      drive(c == rst_at, (c == 0) || (guard && c < wc * 6), (c == 0) ? 16'(wc) : 16'd7, din);
      act_m = c < wc * 6 && (rst_at < 0 || c < rst_at);
      ph = c % 6;
      dv_m = act_m && ph == 4;
      if (rst_at >= 0 && c >= rst_at) dout_m = 16'h0;
      else if (dv_m) dout_m = din;
      check($sformatf("%s c%0d", nm, c), {!(act_m && ph < 4), act_m, dv_m, dv_m && c == wc * 6 - 2, dout_m});
      strobes += int'(data_valid);
      busy_cyc += int'(busy);
    end
    count_check($sformatf("%s strobes", nm), strobes, exp_strobes);
    count_check($sformatf("%s busy_cycles", nm), busy_cyc, exp_busy);
  endtask
  initial begin
    add(1, 0, 16'h0000, 16'h0000, 1, 0, 0, 0, 16'h0000);
    for (int i = 1; i <= 10; i++) add(0, 0, 16'h0000, 16'(i * 4369), 1, 0, 0, 0, 16'h0000);
    add(0, 1, 16'h0001, 16'h1111, 0, 1, 0, 0, 16'h0000);
    add(0, 0, 16'h0000, 16'h2222, 0, 1, 0, 0, 16'h0000);
    add(0, 0, 16'h0000, 16'h3333, 0, 1, 0, 0, 16'h0000);
    add(0, 0, 16'h0000, 16'h4444, 0, 1, 0, 0, 16'h0000);
    add(0, 0, 16'h0000, 16'hA5C3, 1, 1, 1, 1, 16'hA5C3);
    add(0, 0, 16'h0000, 16'h5555, 1, 1, 0, 0, 16'hA5C3);
    add(0, 0, 16'h0000, 16'h6666, 1, 0, 0, 0, 16'hA5C3);
    add(0, 0, 16'h0000, 16'h7777, 1, 0, 0, 0, 16'hA5C3);
    add(0, 1, 16'h0000, 16'h8888, 1, 0, 0, 0, 16'hA5C3);
    add(0, 0, 16'h0000, 16'h9999, 1, 0, 0, 0, 16'hA5C3);
    add(1, 1, 16'h0005, 16'hAAAA, 1, 0, 0, 0, 16'h0000);
    add(0, 0, 16'h0000, 16'hBBBB, 1, 0, 0, 0, 16'h0000);
    add(0, 0, 16'h0000, 16'hCCCC, 1, 0, 0, 0, 16'h0000);
    foreach (q[i]) begin
      drive(q[i].rst, q[i].act, q[i].wc, q[i].din);
      check($sformatf("vec%0d", i), {q[i].re, q[i].bsy, q[i].dv, q[i].lst, q[i].dout});
    end
    burst("burst3", 3, 1'b0, -1, 21, 3, 18);
    burst("guard2", 2, 1'b1, -1, 16, 2, 12);
    burst("midrst4", 4, 1'b0, 7, 24, 1, 7);
    burst("ffff", 65535, 1'b0, 20, 26, 3, 20);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
